centroid_sorter: RTL and testbench
==================================

Name: centroid_sorter

Overview:
Downstream stage of the K-means core. Captures the K centroid words the core emits on its out_valid/out_data burst and sorts them into ascending order of the unsigned key {x,y}. It then presents them one at a time on a valid/ready interface to the result consumer (host readback / compare unit). This gives a canonical centroid order independent of the initial-point seeding.

Parameters:
K, 4, number of centroid words per result set (even, ≥2)
COORD_W, 8, bits per coordinate; word = {x[COORD_W-1:0], y[COORD_W-1:0]}
WORD_W, 16, 2*COORD_W; not overridden independently

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; synchronous, active-low, sampled on rising clk
in_valid  input  1  core out_valid; word present on in_data this cycle
in_data  input  WORD_W  core out_data; {x,y} centroid
out_valid  output  1  sorted word available
out_ready  input  1  consumer accepts word when out_valid&out_ready
out_data  output  WORD_W  sorted centroid; 0 when out_valid=0
out_last  output  1  high with the K-th (largest) word only
busy  output  1  high in any state other than IDLE
err_overrun  output  1  sticky; in_valid seen while in SORT or EMIT

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, word counter=0, buffer entries=0, phase counter=0. Outputs out_valid=0, out_data=0, out_last=0, busy=0, err_overrun=0. Reset mid-operation discards the partial set with no further output.
- All outputs are registered. No combinational path from in_* or out_ready to any output.
- States: IDLE, COLLECT, SORT, EMIT.
- IDLE:
  - in_valid=1: write in_data to buf[0], cnt=1, go to COLLECT.
  - Clear err_overrun on this transition.
- COLLECT:
  - Each in_valid=1 writes buf[cnt] and increments cnt.
  - Gaps (in_valid=0) are allowed; the state holds with no timeout.
  - When the write lands at cnt=K-1: cnt=0, phase=0, go to SORT.
- SORT: odd-even transposition, one phase per cycle, K phases (phase 0..K-1).
  - Even phase compare-swaps pairs (0,1),(2,3),…
  - Odd phase compare-swaps pairs (1,2),(3,4),…
  - Swap only on strictly greater (buf[i] > buf[i+1], unsigned 16-bit), so equal words keep arrival order (stable).
  - After phase K-1: go to EMIT, idx=0, out_valid=1, out_data=buf[0] (post-sort), out_last=(K==1).
  - Timing: first out_valid high exactly K+1 clocks after the edge that captured the K-th input word.
- EMIT:
  - out_valid/out_data/out_last are held stable while out_ready=0.
  - On handshake with idx<K-1: idx++, present buf[idx+1] next cycle with out_valid still 1 (back-to-back, no bubble). out_last=1 when presenting idx=K-1.
  - On handshake with idx=K-1: out_valid=0, out_data=0, out_last=0, go to IDLE.
  - in_valid is not accepted in the same cycle as the final handshake; a new set starts from IDLE the following cycle.
- in_valid=1 during SORT or EMIT: word discarded, buffer untouched, err_overrun=1 until the next IDLE→COLLECT.
- busy = (state != IDLE), registered with the state.
- The counter and index are each $clog2(K) bits and are reset to 0 on every entry to COLLECT/EMIT; no wrap beyond K-1.

Decomposition:
- Shared package kmeans_pkg:
  - K, COORD_W, WORD_W localparams.
  - Sorter state encoding (IDLE=0, COLLECT=1, SORT=2, EMIT=3).
  - The centroid word packing function {x,y}, also used by the core and the SAD path.
- One combinational sub-module: centroid_cmp_swap (inputs a,b; outputs lo,hi; swap iff a>b). Instantiated K/2 times for even phases and K/2-1 times for odd phases, muxed by phase parity.

Test Plan:
- Basic sort: in_valid 4 consecutive cycles with 0x8040,0x1020,0x80FF,0x0000, out_ready=1 → out_valid rises 5 clocks after the last input. Outputs 0x0000,0x1020,0x8040,0x80FF on consecutive cycles; out_last only with 0x80FF; busy falls the cycle after.
- Duplicates/already sorted: 0x5050 ×4, then a separate set 0x0101,0x0202,0x0303,0x0404 → each emitted unchanged in input order; no spurious swaps.
- Reverse order with input gaps: 0xFFFF, gap 2 cycles, 0xFF00, gap 1 cycle, 0x00FF, 0x0000 → output 0x0000,0x00FF,0xFF00,0xFFFF. The state stays COLLECT during the gaps.
- Backpressure: same set as the basic test, out_ready=0 for 3 cycles while 0x1020 is presented → out_data holds 0x1020 with out_valid=1 for those 3 cycles; total 4 handshakes, none duplicated or dropped.
- Overrun: a 5th in_valid word 0x7777 arrives during SORT → err_overrun=1 and stays 1 through EMIT; output set unaffected; err_overrun clears when the next set's first word arrives.
- Reset mid-EMIT: rst_n=0 for 1 cycle after the 2nd handshake → next cycle out_valid=0, out_data=0, busy=0, err_overrun=0. A following fresh set 0x0300,0x0200,0x0100,0x0000 emits 0x0000,0x0100,0x0200,0x0300.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared K-means definitions: result-set size, coordinate/word widths,
// centroid sorter state encoding and the {x,y} word packing helper.
package kmeans_pkg;

  localparam int unsigned K       = 4;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned WORD_W  = 2 * COORD_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StSort    = 2'd2,
    StEmit    = 2'd3
  } sorter_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/centroid_cmp_swap.sv
// Unsigned compare-swap cell: lo/hi ordering of two centroid words.
// Equal inputs pass straight through, which keeps the sort stable.
module centroid_cmp_swap
  import kmeans_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] lo_o,
  output logic [WORD_W-1:0] hi_o
);

  logic swap;

  assign swap = a_i > b_i;
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/centroid_sorter.sv
// Captures a K-word centroid burst, sorts it ascending by {x,y} with an
// odd-even transposition network and replays it on a valid/ready port.
module centroid_sorter
  import kmeans_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_overrun
);

  localparam int unsigned CntW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PhaseW = $clog2(K + 1);

  sorter_state_e               state_q;
  logic [CntW-1:0]             cnt_q;
  logic [CntW-1:0]             idx_q;
  logic [PhaseW-1:0]           phase_q;
  logic [K-1:0][WORD_W-1:0]    word_q;
  logic [K-1:0][WORD_W-1:0]    even_next;
  logic [K-1:0][WORD_W-1:0]    odd_next;
  logic [K-1:0][WORD_W-1:0]    sort_d;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic                        err_q;
  logic [WORD_W-1:0]           out_data_q;

  for (genvar p = 0; p < K / 2; p++) begin : g_even
    centroid_cmp_swap u_cs (
      .a_i  (word_q[2*p]),
      .b_i  (word_q[2*p+1]),
      .lo_o (even_next[2*p]),
      .hi_o (even_next[2*p+1])
    );
  end

  // Odd phase leaves both end words untouched.
  assign odd_next[0]   = word_q[0];
  assign odd_next[K-1] = word_q[K-1];
  for (genvar p = 0; p < K / 2 - 1; p++) begin : g_odd
    centroid_cmp_swap u_cs (
      .a_i  (word_q[2*p+1]),
      .b_i  (word_q[2*p+2]),
      .lo_o (odd_next[2*p+1]),
      .hi_o (odd_next[2*p+2])
    );
  end

  assign sort_d = phase_q[0] ? odd_next : even_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      phase_q     <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q[0] <= in_data;
            cnt_q     <= CntW'(1);
            err_q     <= 1'b0;
            state_q   <= StCollect;
          end
        end
        StCollect: begin
          if (in_valid) begin
            word_q[cnt_q] <= in_data;
            if (cnt_q == CntW'(K - 1)) begin
              cnt_q   <= '0;
              phase_q <= '0;
              state_q <= StSort;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StSort: begin
          if (in_valid) err_q <= 1'b1;
          // Phases 0..K-1 run on consecutive edges; the extra edge at phase K loads the output.
          if (phase_q == PhaseW'(K)) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= word_q[0];
            out_last_q  <= (K == 1);
            state_q     <= StEmit;
          end else begin
            word_q  <= sort_d;
            phase_q <= phase_q + 1'b1;
          end
        end
        StEmit: begin
          if (in_valid) err_q <= 1'b1;
          if (out_ready) begin
            if (idx_q == CntW'(K - 1)) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              state_q     <= StIdle;
            end else begin
              idx_q      <= idx_q + 1'b1;
              out_data_q <= word_q[idx_q + 1'b1];
              out_last_q <= (idx_q == CntW'(K - 2));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q != StIdle);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_centroid_sorter.sv
// Directed plus randomized sets checked against a plain insertion-sort model.
module tb_centroid_sorter;
  import kmeans_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err_overrun;

  int n_cmp = 0;
  int n_err = 0;

  centroid_sorter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void sort_model(input logic [WORD_W-1:0] w[K],
                                     output logic [WORD_W-1:0] s[K]);
    logic [WORD_W-1:0] t;
    s = w;
    for (int i = 1; i < K; i++) begin
      for (int j = i; j > 0; j--) begin
        if (s[j-1] > s[j]) begin
          t = s[j]; s[j] = s[j-1]; s[j-1] = t;
        end
      end
    end
  endfunction

  // Feeds one set (with gaps), optionally injects an overrun word during SORT,
  // and checks the K+1 clock latency to the first out_valid.
  task automatic feed(input logic [WORD_W-1:0] w[K], input int gap[K], input bit ovr);
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      if (i == 0) check("err_clear_on_start", err_overrun, 0);
      check("busy_collect", busy, 1);
      if (i < K - 1) begin
        for (int g = 0; g < gap[i]; g++) begin
          @(negedge clk);
          check("gap_hold", {busy, out_valid}, 2'b10);
        end
      end
    end
    for (int j = 1; j <= K + 1; j++) begin
      if (ovr && j == 1) begin
        in_valid = 1'b1;
        in_data  = 16'h7777;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      if (j == K) check("latency_not_yet", {out_valid, out_data}, 0);
      if (j == K + 1) check("latency_valid", out_valid, 1);
    end
  endtask

  task automatic drain(input logic [WORD_W-1:0] exp[K], input int stall_idx, input int stall_n,
                       input bit rand_ready, input bit exp_err);
    int  idx = 0;
    int  stalls = 0;
    int  guard = 0;
    bit  r;
    while (idx < K && guard < 300) begin
      guard++;
      check("emit_valid", out_valid, 1);
      check("emit_data", out_data, exp[idx]);
      check("emit_last", out_last, (idx == K - 1));
      check("emit_err", err_overrun, exp_err);
      check("emit_busy", busy, 1);
      if (idx == stall_idx && stalls < stall_n) begin
        r = 1'b0;
        stalls++;
      end else if (rand_ready) begin
        r = 1'($urandom_range(0, 1));
      end else begin
        r = 1'b1;
      end
      out_ready = r;
      @(negedge clk);
      if (r) idx++;
    end
    check("emit_count", idx, K);
    check("after_last", {out_valid, out_last, busy, out_data}, 0);
    check("err_after_set", err_overrun, exp_err);
    out_ready = 1'b0;
  endtask

  task automatic run_set(input logic [WORD_W-1:0] w[K], input int gap[K], input bit ovr,
                         input int stall_idx, input int stall_n, input bit rand_ready);
    logic [WORD_W-1:0] e[K];
    sort_model(w, e);
    feed(w, gap, ovr);
    drain(e, stall_idx, stall_n, rand_ready, ovr);
  endtask

  initial begin
    logic [WORD_W-1:0] w[K];
    int                g0[K];
    int                gr[K];

    g0 = '{0, 0, 0, 0};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {out_valid, out_last, busy, err_overrun, out_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_quiet", {out_valid, busy}, 0);

    // Basic sort
    w = '{16'h8040, 16'h1020, 16'h80FF, 16'h0000};
    run_set(w, g0, 1'b0, -1, 0, 1'b0);

    // Duplicates, then already sorted
    w = '{16'h5050, 16'h5050, 16'h5050, 16'h5050};
    run_set(w, g0, 1'b0, -1, 0, 1'b0);
    w = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    run_set(w, g0, 1'b0, -1, 0, 1'b0);

    // Reverse order with input gaps
    w = '{16'hFFFF, 16'hFF00, 16'h00FF, 16'h0000};
    gr = '{2, 1, 0, 0};
    run_set(w, gr, 1'b0, -1, 0, 1'b0);

    // Backpressure on the second word
    w = '{16'h8040, 16'h1020, 16'h80FF, 16'h0000};
    run_set(w, g0, 1'b0, 1, 3, 1'b0);

    // Overrun during SORT; the next set must clear the flag on its first word
    run_set(w, g0, 1'b1, -1, 0, 1'b0);

    // Randomized sets: full-range and narrow-range (forces duplicates)
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < K; i++) begin
        if (s[0])
          w[i] = pack_word(8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)));
        else
          w[i] = pack_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        gr[i] = $urandom_range(0, 2);
      end
      run_set(w, gr, 1'(s == 5), -1, 0, 1'b1);
    end

    // Reset mid-EMIT after two handshakes
    w = '{16'h4444, 16'h1111, 16'h3333, 16'h2222};
    feed(w, g0, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_outputs", {out_valid, busy, err_overrun, out_last, out_data}, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_more", {out_valid, busy}, 0);
    out_ready = 1'b0;

    w = '{16'h0300, 16'h0200, 16'h0100, 16'h0000};
    run_set(w, g0, 1'b0, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
